// File: rtl/freq_count_pkg.sv
// Shared types and constants for the frequency counter measurement controller.
package freq_count_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        TENS  = 2'd1,
        UNITS = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam int MAX_DISPLAY = 99;
    localparam int DIGIT_BASE  = 10;
    // Narrowest work register that can hold MAX_DISPLAY.
    localparam int WORK_W      = 7;

endpackage

// File: rtl/bcd_split.sv
// Splits a clamped count (0..99) into BCD tens/units by repeated subtraction of
// DIGIT_BASE, one subtraction per cycle, with a done strobe on the final cycle.
module bcd_split
    import freq_count_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic [WORK_W-1:0] i_work,
    output bcd_t              o_tens,
    output bcd_t              o_units,
    output logic              o_done
);
    logic [WORK_W-1:0] r_work;
    bcd_t              r_tens_acc;
    logic              r_busy;
    logic              w_ge_base;

    assign w_ge_base = (r_work >= WORK_W'(DIGIT_BASE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_work     <= '0;
            r_tens_acc <= '0;
            r_busy     <= 1'b0;
        end else if (i_clear) begin
            r_work     <= '0;
            r_tens_acc <= '0;
            r_busy     <= 1'b0;
        end else if (i_start) begin
            r_work     <= i_work;
            r_tens_acc <= '0;
            r_busy     <= 1'b1;
        end else if (r_busy) begin
            if (w_ge_base) begin
                r_work     <= r_work - WORK_W'(DIGIT_BASE);
                r_tens_acc <= r_tens_acc + 4'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    // Done is the cycle the remainder drops below one digit; the digits are final then.
    assign o_done  = r_busy && !w_ge_base;
    assign o_tens  = r_tens_acc;
    assign o_units = r_work[3:0];

endmodule

// File: rtl/freq_count_ctrl.sv
// Frequency counter measurement controller: gated edge counting, BCD conversion
// and publication of the result with a one-cycle valid strobe.
module freq_count_ctrl
    import freq_count_pkg::*;
#(
    parameter int COUNT_W     = 7,
    parameter int PERIOD_W    = 12,
    parameter int GATE_CYCLES = 1200
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                edge_pulse,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_load,
    output logic [3:0]          tens,
    output logic [3:0]          units,
    output logic                overflow,
    output logic                valid
);
    localparam logic [COUNT_W-1:0] EDGE_MAX = '1;

    state_e              r_state;
    state_e              w_next_state;
    logic [PERIOD_W-1:0] r_cyc_cnt;
    logic [PERIOD_W-1:0] r_active_period;
    logic [PERIOD_W-1:0] r_pending_period;
    logic [COUNT_W-1:0]  r_edge_cnt;
    logic [COUNT_W-1:0]  w_edge_next;
    logic [31:0]         w_final;
    logic                w_clamp;
    logic                w_window_end;
    logic                w_start;
    logic                w_done;
    logic                r_ovf;
    logic [WORK_W-1:0]   w_work;
    bcd_t                w_split_tens;
    bcd_t                w_split_units;
    bcd_t                r_tens;
    bcd_t                r_units;
    logic                r_overflow;

    assign w_edge_next  = (edge_pulse && (r_edge_cnt != EDGE_MAX)) ? r_edge_cnt + COUNT_W'(1) : r_edge_cnt;
    assign w_final      = 32'(w_edge_next);
    assign w_clamp      = (w_final > 32'(MAX_DISPLAY));
    assign w_work       = w_clamp ? WORK_W'(MAX_DISPLAY) : WORK_W'(w_final);
    assign w_window_end = (r_state == COUNT) && (r_cyc_cnt == r_active_period - PERIOD_W'(1));
    assign w_start      = enable && w_window_end;

    bcd_split u_bcd_split (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_start),
        .i_clear (!enable),
        .i_work  (w_work),
        .o_tens  (w_split_tens),
        .o_units (w_split_units),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= COUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COUNT:   if (w_window_end) w_next_state = TENS;
            TENS:    if (w_done) w_next_state = UNITS;
            UNITS:   w_next_state = COUNT;
            default: w_next_state = COUNT;
        endcase
        if (!enable) begin
            w_next_state = COUNT;
        end
    end

    // Edges arriving outside COUNT are discarded; the next window starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc_cnt  <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (!enable) begin
            r_cyc_cnt  <= '0;
            r_edge_cnt <= '0;
        end else if (r_state == COUNT) begin
            if (w_window_end) begin
                r_cyc_cnt  <= '0;
                r_edge_cnt <= '0;
                r_ovf      <= w_clamp;
            end else begin
                r_cyc_cnt  <= r_cyc_cnt + PERIOD_W'(1);
                r_edge_cnt <= w_edge_next;
            end
        end else begin
            r_cyc_cnt  <= '0;
            r_edge_cnt <= '0;
        end
    end

    // Active period picks up the pending value that existed before any same-cycle load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending_period <= PERIOD_W'(GATE_CYCLES);
            r_active_period  <= PERIOD_W'(GATE_CYCLES);
        end else begin
            if (period_load) begin
                r_pending_period <= (period_in == '0) ? PERIOD_W'(1) : period_in;
            end
            if (r_state == UNITS) begin
                r_active_period <= r_pending_period;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tens     <= '0;
            r_units    <= '0;
            r_overflow <= 1'b0;
        end else if (enable && (r_state == TENS) && w_done) begin
            r_tens     <= w_split_tens;
            r_units    <= w_split_units;
            r_overflow <= r_ovf;
        end
    end

    assign tens     = r_tens;
    assign units    = r_units;
    assign overflow = r_overflow;
    assign valid    = (r_state == UNITS);

endmodule

// File: tb/tb_freq_count_ctrl.sv
// Scoreboard bench for freq_count_ctrl: a window-level reference model predicts each
// published result and its cycle; a monitor pops and compares on every valid.
module tb_freq_count_ctrl;

    localparam int COUNT_W     = 7;
    localparam int PERIOD_W    = 12;
    localparam int GATE_CYCLES = 100;
    localparam int EDGE_SAT    = (1 << COUNT_W) - 1;

    typedef struct {
        int tensExp;
        int unitsExp;
        int ovfExp;
        int dueCycle;
    } expect_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic                enable = 1'b0;
    logic                edgePulse = 1'b0;
    logic [PERIOD_W-1:0] periodIn = '0;
    logic                periodLoad = 1'b0;
    logic [3:0]          tens;
    logic [3:0]          units;
    logic                overflow;
    logic                valid;

    expect_t scoreboard[$];
    int      assertCount = 0;
    int      failCount = 0;
    int      tbCycle = 0;

    int      modelConverting = 0;
    int      modelPos = 0;
    int      modelCnt = 0;
    int      modelBusy = 0;
    int      modelActive = GATE_CYCLES;
    int      modelPending = GATE_CYCLES;
    int      modelTotal;
    int      modelShown;
    expect_t modelEntry;
    expect_t monEntry;
    logic [3:0] prevTens = '0;
    logic [3:0] prevUnits = '0;
    logic       prevOvf = 1'b0;

    always #5 clk = ~clk;

    freq_count_ctrl #(
        .COUNT_W     (COUNT_W),
        .PERIOD_W    (PERIOD_W),
        .GATE_CYCLES (GATE_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .edge_pulse  (edgePulse),
        .period_in   (periodIn),
        .period_load (periodLoad),
        .tens        (tens),
        .units       (units),
        .overflow    (overflow),
        .valid       (valid)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, tbCycle);
        end
    endtask

    // Reference model: a window lasts activePeriod cycles, the result appears
    // floor(shown/10)+2 cycles after the last window cycle, then a new window begins.
    always @(posedge clk) begin
        if (!reset_n) begin
            modelConverting = 0;
            modelPos        = 0;
            modelCnt        = 0;
            modelBusy       = 0;
            modelActive     = GATE_CYCLES;
            modelPending    = GATE_CYCLES;
            scoreboard.delete();
        end else begin
            if (!enable) begin
                if (modelConverting != 0 && modelBusy >= 2) begin
                    if (scoreboard.size() > 0) void'(scoreboard.pop_back());
                end else if (modelConverting != 0 && modelBusy == 1) begin
                    modelActive = modelPending;
                end
                modelConverting = 0;
                modelPos        = 0;
                modelCnt        = 0;
            end else if (modelConverting == 0) begin
                modelTotal = modelCnt + (edgePulse ? 1 : 0);
                if (modelTotal > EDGE_SAT) modelTotal = EDGE_SAT;
                if (modelPos == modelActive - 1) begin
                    modelShown          = (modelTotal > 99) ? 99 : modelTotal;
                    modelEntry.tensExp  = modelShown / 10;
                    modelEntry.unitsExp = modelShown % 10;
                    modelEntry.ovfExp   = (modelTotal > 99) ? 1 : 0;
                    modelEntry.dueCycle = tbCycle + modelShown / 10 + 2;
                    scoreboard.push_back(modelEntry);
                    modelConverting = 1;
                    modelBusy       = modelShown / 10 + 2;
                end else begin
                    modelPos = modelPos + 1;
                    modelCnt = modelTotal;
                end
            end else begin
                modelBusy = modelBusy - 1;
                if (modelBusy == 0) begin
                    modelActive     = modelPending;
                    modelConverting = 0;
                    modelPos        = 0;
                    modelCnt        = 0;
                end
            end
            if (periodLoad) modelPending = (periodIn == '0) ? 1 : int'(periodIn);
        end
        tbCycle++;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("validInReset", 32'(valid), 32'd0);
            prevTens  = tens;
            prevUnits = units;
            prevOvf   = overflow;
        end else if (valid === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpectedValid", 32'(valid), 32'd0);
            end else begin
                monEntry = scoreboard.pop_front();
                checkOutput("tens", 32'(tens), 32'(monEntry.tensExp));
                checkOutput("units", 32'(units), 32'(monEntry.unitsExp));
                checkOutput("overflow", 32'(overflow), 32'(monEntry.ovfExp));
                checkOutput("validCycle", 32'(tbCycle), 32'(monEntry.dueCycle));
            end
            prevTens  = tens;
            prevUnits = units;
            prevOvf   = overflow;
        end else begin
            checkOutput("outputHold", {23'd0, tens, units, overflow}, {23'd0, prevTens, prevUnits, prevOvf});
        end
    end

    task automatic applyStimulus(input logic pulse, input logic load, input int loadVal);
        @(negedge clk);
        enable     = 1'b1;
        edgePulse  = pulse;
        periodLoad = load;
        periodIn   = PERIOD_W'(loadVal);
    endtask

    task automatic applyWindow(input int len, input int pulseEvery, input int pulseCount,
                               input int loadAt, input int loadVal);
        for (int i = 0; i < len; i++) begin
            applyStimulus((pulseEvery > 0) && (i % pulseEvery == 0) && (i / pulseEvery < pulseCount),
                          (i == loadAt), loadVal);
        end
    endtask

    task automatic waitValid(input int budget, output int waited);
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (valid === 1'b1) return;
            edgePulse  = 1'b0;
            periodLoad = 1'b0;
        end
        checkOutput("validTimeout", 32'(valid), 32'd1);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset_n    = 1'b1;
        enable     = 1'b1;
        edgePulse  = 1'b0;
        periodLoad = 1'b0;
    endtask

    initial begin
        int waited;
        int lowLeft;
        bit stale;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetTens", 32'(tens), 32'd0);
        checkOutput("resetUnits", 32'(units), 32'd0);
        checkOutput("resetOverflow", 32'(overflow), 32'd0);
        checkOutput("resetValid", 32'(valid), 32'd0);
        releaseReset();

        $display("[TB] basic window");
        applyWindow(99, 2, 37, -1, 0);
        waitValid(40, waited);
        checkOutput("basicLatency", 32'(waited), 32'd5);
        checkOutput("basicDigits", {24'd0, tens, units}, {24'd0, 4'd3, 4'd7});

        $display("[TB] boundary edges and mid-window period load");
        applyWindow(100, 99, 2, 40, 50);
        applyStimulus(1'b1, 1'b0, 0);
        waitValid(40, waited);
        checkOutput("boundaryLatency", 32'(waited + 1), 32'd2);
        checkOutput("boundaryDigits", {24'd0, tens, units}, {24'd0, 4'd0, 4'd2});

        applyWindow(50, 7, 7, 10, 200);
        waitValid(40, waited);
        checkOutput("shortWindowLatency", 32'(waited), 32'd2);
        checkOutput("shortWindowDigits", {24'd0, tens, units}, {24'd0, 4'd0, 4'd7});

        $display("[TB] overflow");
        applyWindow(200, 1, 120, 150, 100);
        waitValid(40, waited);
        checkOutput("overflowLatency", 32'(waited), 32'd11);
        checkOutput("overflowDigits", {23'd0, tens, units, overflow}, {23'd0, 4'd9, 4'd9, 1'b1});

        applyWindow(100, 20, 5, 50, 0);
        waitValid(40, waited);
        checkOutput("afterOverflowDigits", {23'd0, tens, units, overflow}, {23'd0, 4'd0, 4'd5, 1'b0});

        $display("[TB] one-cycle window from period 0");
        applyWindow(1, 1, 1, 0, 100);
        waitValid(10, waited);
        checkOutput("periodZeroLatency", 32'(waited), 32'd2);
        checkOutput("periodZeroDigits", {24'd0, tens, units}, {24'd0, 4'd0, 4'd1});

        $display("[TB] enable drop");
        applyWindow(30, 1, 20, -1, 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            enable    = 1'b0;
            edgePulse = 1'b1;
        end
        checkOutput("enableHoldDigits", {23'd0, tens, units, overflow}, {23'd0, 4'd0, 4'd1, 1'b0});
        applyWindow(100, 25, 4, -1, 0);
        waitValid(40, waited);
        checkOutput("reenableLatency", 32'(waited), 32'd2);
        checkOutput("reenableDigits", {24'd0, tens, units}, {24'd0, 4'd0, 4'd4});

        $display("[TB] async reset during conversion");
        applyWindow(100, 4, 25, 10, 30);
        @(negedge clk);
        edgePulse  = 1'b0;
        periodLoad = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midResetOutputs", {23'd0, tens, units, overflow}, 32'd0);
        checkOutput("midResetValid", 32'(valid), 32'd0);
        repeat (2) @(negedge clk);
        releaseReset();
        applyWindow(99, 10, 9, -1, 0);
        waitValid(40, waited);
        checkOutput("postResetLatency", 32'(waited), 32'd2);
        checkOutput("postResetDigits", {24'd0, tens, units}, {24'd0, 4'd0, 4'd9});

        $display("[TB] randomized traffic");
        lowLeft = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (lowLeft > 0) begin
                enable = 1'b0;
                lowLeft--;
            end else begin
                enable = 1'b1;
                if ($urandom_range(0, 99) == 0) lowLeft = $urandom_range(1, 6);
            end
            edgePulse  = ($urandom_range(0, 2) == 0);
            periodLoad = ($urandom_range(0, 39) == 0);
            periodIn   = ($urandom_range(0, 4) == 0) ? PERIOD_W'($urandom_range(300, 400))
                                                     : PERIOD_W'($urandom_range(0, 60));
        end

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            enable     = 1'b1;
            edgePulse  = 1'b0;
            periodLoad = 1'b0;
        end
        stale = (scoreboard.size() > 0) && (scoreboard[0].dueCycle < tbCycle);
        checkOutput("staleExpectations", 32'(stale), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
